// File: rtl/hazard_forward_unit_if.sv
// Decode-to-hazard-unit bundle: decode fields in, operand selects / bank write index out.
// Latency: carries no state; the hazard unit registers selects one cycle after decode.
// Backpressure: `stall` is the only flow control; decode holds its fields while it is high.
interface hazard_forward_unit_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] RA_id;
  logic [REG_AW-1:0] RB_id;
  logic [REG_AW-1:0] RW_id;
  logic              wr_id;
  logic              ld_id;
  logic              imm_id;
  logic [1:0]        mux_sel_A;
  logic [1:0]        mux_sel_B;
  logic              imm_sel;
  logic [REG_AW-1:0] RW_dm;
  logic              ex_valid;
  logic              stall;

  // Decoder side: drives the decode slot, observes selects and stall.
  modport master (
    output id_valid, RA_id, RB_id, RW_id, wr_id, ld_id, imm_id,
    input  mux_sel_A, mux_sel_B, imm_sel, RW_dm, ex_valid, stall
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, RA_id, RB_id, RW_id, wr_id, ld_id, imm_id,
    output mux_sel_A, mux_sel_B, imm_sel, RW_dm, ex_valid, stall
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding control: tracks 3 in-flight dests, drives operand selects, RW_dm and load-use stall.
// Latency: selects/imm_sel/ex_valid registered one cycle after decode; stall combinational same cycle.
// Backpressure: stall holds decode and shifts a bubble; HFU_FORWARDING_EN selects forwarding, else stall-until-clear.
module hazard_forward_unit #(
  parameter int REG_AW = 5
) (
  input logic              clk,
  input logic              rst,
  hazard_forward_unit_if.slave hfu
);

  typedef struct packed {
    logic              vld;
    logic              wr;
    logic [REG_AW-1:0] dest;
  } slot_t;

  // s1 = EX, s2 = DM, s3 = WB
  slot_t s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic       imm_sel_q, imm_sel_d;
  logic       ex_valid_q, ex_valid_d;
  logic       ra_used, rb_used, stall_c, issue;

  // A slot counts as a producer only when it is real, writes, and does not target the r0 sink.
  function automatic logic hit(input slot_t s, input logic [REG_AW-1:0] x, input logic used);
    return used && s.vld && s.wr && (s.dest != '0) && (s.dest == x);
  endfunction

`ifdef HFU_FORWARDING_EN
  logic s1_ld_q, s1_ld_d;

  // Nearest producer wins: EX result, then DM, then WB; otherwise the bank is current.
  function automatic logic [1:0] fwd_sel(input slot_t a, input slot_t b, input slot_t c,
                                         input logic [REG_AW-1:0] x, input logic used);
    if (hit(a, x, used))      return 2'b01;
    else if (hit(b, x, used)) return 2'b10;
    else if (hit(c, x, used)) return 2'b11;
    else                      return 2'b00;
  endfunction
`endif

  // Source usage and hazard detection from the decode slot against the in-flight slots.
  always_comb begin
    ra_used = hfu.id_valid && (hfu.RA_id != '0);
    rb_used = hfu.id_valid && !hfu.imm_id && (hfu.RB_id != '0);
`ifdef HFU_FORWARDING_EN
    // Only a load in EX cannot be forwarded in time.
    stall_c = s1_ld_q && (hit(s1_q, hfu.RA_id, ra_used) || hit(s1_q, hfu.RB_id, rb_used));
`else
    // Without forwarding, wait until every pending writer of a used source has retired.
    stall_c = hit(s1_q, hfu.RA_id, ra_used) || hit(s1_q, hfu.RB_id, rb_used) ||
              hit(s2_q, hfu.RA_id, ra_used) || hit(s2_q, hfu.RB_id, rb_used) ||
              hit(s3_q, hfu.RA_id, ra_used) || hit(s3_q, hfu.RB_id, rb_used);
`endif
    if (rst) stall_c = 1'b0;
    issue = hfu.id_valid && !stall_c;
  end

  // Tracking shift: decode (or a bubble) enters s1, older slots move down every cycle.
  always_comb begin
    s1_d = '0;
    if (issue) begin
      s1_d.vld  = 1'b1;
      s1_d.wr   = hfu.wr_id;
      s1_d.dest = hfu.RW_id;
    end
    s2_d       = s1_q;
    s3_d       = s2_q;
    ex_valid_d = issue;
    imm_sel_d  = issue && hfu.imm_id;
`ifdef HFU_FORWARDING_EN
    s1_ld_d    = issue && hfu.ld_id;
`endif
  end

  // Operand selects for the instruction entering EX; bubbles read the bank.
  always_comb begin
    sel_a_d = 2'b00;
    sel_b_d = 2'b00;
`ifdef HFU_FORWARDING_EN
    if (issue) begin
      sel_a_d = fwd_sel(s1_q, s2_q, s3_q, hfu.RA_id, ra_used);
      sel_b_d = fwd_sel(s1_q, s2_q, s3_q, hfu.RB_id, rb_used);
    end
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      sel_a_q    <= 2'b00;
      sel_b_q    <= 2'b00;
      imm_sel_q  <= 1'b0;
      ex_valid_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      imm_sel_q  <= imm_sel_d;
      ex_valid_q <= ex_valid_d;
    end
  end

`ifdef HFU_FORWARDING_EN
  // Load flag of the EX slot, needed only for the load-use check.
  always_ff @(posedge clk) begin
    if (rst) s1_ld_q <= 1'b0;
    else     s1_ld_q <= s1_ld_d;
  end
`endif

  // Bank has no write enable, so non-writers and bubbles in DM aim at r0.
  assign hfu.RW_dm     = (s2_q.vld && s2_q.wr) ? s2_q.dest : '0;
  assign hfu.mux_sel_A = sel_a_q;
  assign hfu.mux_sel_B = sel_b_q;
  assign hfu.imm_sel   = imm_sel_q;
  assign hfu.ex_valid  = ex_valid_q;
  assign hfu.stall     = stall_c;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit with an in-order history model and scoreboard.
// Latency: expected EX-stage outputs are queued at decode and compared one edge later.
// Backpressure: instructions are re-presented while the model predicts stall, bounded per instruction.
module tb_hazard_forward_unit;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_AW(AW)) hfu ();
  hazard_forward_unit #(.REG_AW(AW)) dut (.clk(clk), .rst(rst), .hfu(hfu));

  typedef struct packed {
    logic          vld;
    logic          wr;
    logic          ld;
    logic [AW-1:0] dest;
  } ent_t;

  typedef struct packed {
    logic [1:0] sa;
    logic [1:0] sb;
    logic       imm;
    logic       exv;
  } exp_t;

  ent_t hist [3];   // hist[0] = most recently issued slot (EX)
  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic writes(input ent_t e);
    return e.vld && e.wr && (e.dest != '0);
  endfunction

  function automatic logic [1:0] m_sel(input logic [AW-1:0] x, input logic used);
`ifdef HFU_FORWARDING_EN
    for (int i = 0; i < 3; i++)
      if (used && writes(hist[i]) && hist[i].dest == x) return 2'(i + 1);
`endif
    return 2'b00;
  endfunction

  function automatic logic m_stall(input logic ua, input logic [AW-1:0] ra,
                                   input logic ub, input logic [AW-1:0] rb);
`ifdef HFU_FORWARDING_EN
    return writes(hist[0]) && hist[0].ld &&
           ((ua && hist[0].dest == ra) || (ub && hist[0].dest == rb));
`else
    for (int i = 0; i < 3; i++)
      if (writes(hist[i]) && ((ua && hist[i].dest == ra) || (ub && hist[i].dest == rb)))
        return 1'b1;
    return 1'b0;
`endif
  endfunction

  // One decode cycle: drive, check stall/RW_dm, queue expectations, then check EX outputs.
  task automatic step(input logic idv, input logic [AW-1:0] ra, rb, rw,
                      input logic wr, ld, imm, output logic stalled);
    logic ua, ub, es, iss;
    exp_t e, got;
    ent_t n;
    @(negedge clk);
    hfu.id_valid = idv; hfu.RA_id = ra; hfu.RB_id = rb; hfu.RW_id = rw;
    hfu.wr_id = wr; hfu.ld_id = ld; hfu.imm_id = imm;
    #1;
    ua  = idv && ra != '0;
    ub  = idv && !imm && rb != '0;
    es  = m_stall(ua, ra, ub, rb);
    iss = idv && !es;
    chk("stall", hfu.stall, es);
    chk("rw_dm", hfu.RW_dm, writes(hist[1]) ? hist[1].dest : 0);
    e.sa  = iss ? m_sel(ra, ua) : 2'b00;
    e.sb  = iss ? m_sel(rb, ub) : 2'b00;
    e.imm = iss && imm;
    e.exv = iss;
    sb_q.push_back(e);
    n = '0;
    if (iss) begin n.vld = 1'b1; n.wr = wr; n.ld = ld; n.dest = rw; end
    @(posedge clk); #1;
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = n;
    if (sb_q.size() == 0) chk("sb_empty", 0, 1);
    else begin
      got = sb_q.pop_front();
      chk("sel_a", hfu.mux_sel_A, got.sa);
      chk("sel_b", hfu.mux_sel_B, got.sb);
      chk("imm_sel", hfu.imm_sel, got.imm);
      chk("ex_valid", hfu.ex_valid, got.exv);
    end
    stalled = es;
  endtask

  task automatic issue_ins(input logic [AW-1:0] ra, rb, rw, input logic wr, ld, imm,
                           output int nst);
    logic st;
    nst = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, ra, rb, rw, wr, ld, imm, st);
      if (!st) return;
      nst++;
    end
    chk("stall_bound", nst, 3);
  endtask

  task automatic bubbles(input int n);
    logic st;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, st);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sel_a"}, hfu.mux_sel_A, 0);
    chk({tag, "_sel_b"}, hfu.mux_sel_B, 0);
    chk({tag, "_imm"}, hfu.imm_sel, 0);
    chk({tag, "_exv"}, hfu.ex_valid, 0);
    chk({tag, "_rwdm"}, hfu.RW_dm, 0);
  endtask

  initial begin
    int ns;
    logic st;
    for (int i = 0; i < 3; i++) hist[i] = '0;

    // Reset with a hazard-looking decode slot present.
    rst = 1'b1;
    hfu.id_valid = 1'b1; hfu.RA_id = 5'd2; hfu.RB_id = 5'd2; hfu.RW_id = 5'd2;
    hfu.wr_id = 1'b1; hfu.ld_id = 1'b1; hfu.imm_id = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", hfu.stall, 0);
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    hfu.id_valid = 1'b0;

    // ADD r3 <- r1,r2 then SUB r5 <- r3,r4
    issue_ins(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, ns);
    issue_ins(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, ns);
`ifdef HFU_FORWARDING_EN
    chk("addsub_nstall", ns, 0);
    chk("addsub_sel_a", hfu.mux_sel_A, 1);
`else
    chk("nofwd_nstall", ns, 3);
    chk("nofwd_sel_a", hfu.mux_sel_A, 0);
`endif
    chk("addsub_sel_b", hfu.mux_sel_B, 0);

    // Writer to r7, then gaps of 1, 2, 3 slots before a reader of r7.
    for (int g = 1; g <= 3; g++) begin
      bubbles(3);
      issue_ins(5'd1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, ns);
      bubbles(1);
      chk("rw_dm7", hfu.RW_dm, 7);
      if (g > 1) bubbles(g - 1);
      issue_ins(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, ns);
`ifdef HFU_FORWARDING_EN
      chk($sformatf("gap%0d_sel_a", g), hfu.mux_sel_A, (g == 1) ? 2 : (g == 2) ? 3 : 0);
`else
      chk($sformatf("gap%0d_sel_a", g), hfu.mux_sel_A, 0);
`endif
    end

    // LW r2 then ADD r6 <- r2,r2
    bubbles(3);
    issue_ins(5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, ns);
    issue_ins(5'd2, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, ns);
`ifdef HFU_FORWARDING_EN
    chk("lu_nstall", ns, 1);
    chk("lu_sel_a", hfu.mux_sel_A, 2);
    chk("lu_sel_b", hfu.mux_sel_B, 2);
`else
    chk("lu_nstall", ns, 3);
`endif

    // Writer to r0 then reader of r0; non-writer to r9 then reader of r9.
    bubbles(3);
    issue_ins(5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, ns);
    issue_ins(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, ns);
    chk("r0_nstall", ns, 0);
    issue_ins(5'd1, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0, ns);
    issue_ins(5'd9, 5'd9, 5'd4, 1'b1, 1'b0, 1'b0, ns);
    chk("nowr_nstall", ns, 0);
    chk("nowr_sel_b", hfu.mux_sel_B, 0);

    // Immediate operand hides RB from the load in EX.
    bubbles(3);
    issue_ins(5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, ns);
    issue_ins(5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1, ns);
    chk("imm_nstall", ns, 0);
    chk("imm_sel_hi", hfu.imm_sel, 1);

    // Reset during a stall.
    bubbles(3);
    issue_ins(5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, ns);
    @(negedge clk);
    hfu.id_valid = 1'b1; hfu.RA_id = 5'd2; hfu.RB_id = 5'd0; hfu.RW_id = 5'd6;
    hfu.wr_id = 1'b1; hfu.ld_id = 1'b0; hfu.imm_id = 1'b0;
    #1;
    chk("mid_pre_stall", hfu.stall, 1);
    rst = 1'b1;
    #1;
    chk("mid_stall_drop", hfu.stall, 0);
    @(posedge clk); #1;
    check_reset_outputs("mid");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
    sb_q.delete();
    issue_ins(5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, ns);
    chk("post_rst_nstall", ns, 0);
    chk("post_rst_sel_a", hfu.mux_sel_A, 0);

    // Random traffic over a small register set to provoke overlaps.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, st);
      else issue_ins(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) == 0), ns);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
